gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker.sv | 117 +++++++++++
 tb/tb_gate_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// gate_checker: exhaustively drives the four input combinations of a
// 2-input gate, holds each for SETTLE+1 cycles, and compares the gate's
// output against the TRUTH table. Reports per-vector failures and a count.
module gate_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0110,  // expected output, index = {a,b}
    parameter int unsigned SETTLE = 2         // extra hold cycles, 0..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t     state, state_nx;
    logic [1:0] v, v_nx;
    logic [3:0] cnt, cnt_nx;
    logic       a_nx, b_nx, busy_nx, done_nx, pass_nx;
    logic [2:0] err_nx;
    logic [3:0] fv_nx;

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            v         <= 2'd0;
            cnt       <= 4'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            state     <= state_nx;
            v         <= v_nx;
            cnt       <= cnt_nx;
            dut_a     <= a_nx;
            dut_b     <= b_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            err_count <= err_nx;
            fail_vec  <= fv_nx;
        end
    end

    // Next-state and next-output logic; gate inputs default to 00 off-run.
    always_comb begin
        state_nx = state;
        v_nx     = v;
        cnt_nx   = cnt;
        a_nx     = 1'b0;
        b_nx     = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        pass_nx  = pass;
        err_nx   = err_count;
        fv_nx    = fail_vec;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = DRIVE;
                    v_nx     = 2'd0;
                    cnt_nx   = 4'd0;
                    err_nx   = 3'd0;
                    fv_nx    = 4'd0;
                    busy_nx  = 1'b1;
                    pass_nx  = 1'b0;
                end
            end
            DRIVE: begin
                busy_nx       = 1'b1;
                {a_nx, b_nx}  = v;
                if (cnt == SETTLE_C) begin
                    // Sample point for vector v: gate has been stable SETTLE+1 cycles.
                    if (dut_out != TRUTH[v]) begin
                        fv_nx[v] = 1'b1;
                        err_nx   = err_count + 3'd1;
                    end
                    cnt_nx = 4'd0;
                    if (v != 2'd3) begin
                        v_nx         = v + 2'd1;
                        {a_nx, b_nx} = v_nx;
                    end else begin
                        state_nx = DONE;
                        v_nx     = 2'd0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        a_nx     = 1'b0;
                        b_nx     = 1'b0;
                        pass_nx  = (err_nx == 3'd0);
                    end
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DONE: begin
                // start is deliberately ignored here; a held start restarts from IDLE.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: two instances (default XOR config and AND with
// SETTLE=0), each driving a table-based gate model. Expected results come
// from gate-table vs truth-table arithmetic and a cycle-position model.
module tb_gate_checker;

    localparam logic [3:0] T0 = 4'b0110;
    localparam int         S0 = 2;
    localparam logic [3:0] T1 = 4'b1000;
    localparam int         S1 = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start, dout, a, b, busy, done, pass;
    logic [1:0][2:0] err;
    logic [1:0][3:0] fv;
    logic [3:0] gt [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign dout[0] = gt[0][{a[0], b[0]}];
    assign dout[1] = gt[1][{a[1], b[1]}];

    gate_checker #(.TRUTH(T0), .SETTLE(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_out(dout[0]),
        .dut_a(a[0]), .dut_b(b[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0]));

    gate_checker #(.TRUTH(T1), .SETTLE(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_out(dout[1]),
        .dut_a(a[1]), .dut_b(b[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_all(input int k, input string tag);
        chk({tag, "_busy"}, busy[k], 0);
        chk({tag, "_done"}, done[k], 0);
        chk({tag, "_ab"},   {a[k], b[k]}, 0);
    endtask

    task automatic wait_done(input int k);
        int to = 0;
        while (done[k] !== 1'b1 && to < 200) begin
            @(negedge clk);
            to++;
        end
        chk("done_wait", done[k], 1);
    endtask

    // One full run on instance k with gate table g; optionally pokes start mid-run.
    task automatic run_check(input int k, input logic [3:0] g, input bit poke);
        int s, nb, to;
        logic [3:0] t, efv;
        s = (k != 0) ? S1 : S0;
        t = (k != 0) ? T1 : T0;
        gt[k] = g;
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
        nb = 0; to = 0;
        while (done[k] !== 1'b1 && to < 200) begin
            if (busy[k] === 1'b1) begin
                chk("ab_seq", {a[k], b[k]}, nb / (s + 1));
                nb++;
            end
            @(negedge clk);
            to++;
            start[k] = (poke && nb == 2);
        end
        start[k] = 1'b0;
        efv = g ^ t;
        chk("done_seen",   done[k], 1);
        chk("busy_cycles", nb, 4 * (s + 1));
        chk("busy_at_done", busy[k], 0);
        chk("ab_at_done",  {a[k], b[k]}, 0);
        chk("fail_vec",    fv[k], efv);
        chk("err_count",   err[k], $countones(efv));
        chk("pass",        pass[k], efv == 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_all(k, "after_done");
            chk("hold_fv",   fv[k], efv);
            chk("hold_pass", pass[k], efv == 4'd0);
        end
    endtask

    initial begin
        int to;
        rst_n = 1'b0;
        start = 2'b00;
        gt[0] = 4'b0110;
        gt[1] = 4'b1000;
        #12;
        for (int k = 0; k < 2; k++) begin
            chk_idle_all(k, "reset");
            chk("reset_pass", pass[k], 0);
            chk("reset_err",  err[k], 0);
            chk("reset_fv",   fv[k], 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: XOR good, stuck-at-0, XNOR, AND with SETTLE=0.
        run_check(0, 4'b0110, 1'b0);
        run_check(0, 4'b0000, 1'b0);
        run_check(0, 4'b1001, 1'b0);
        run_check(1, 4'b1000, 1'b0);

        // start pulses during busy must not queue another run.
        run_check(0, 4'b0110, 1'b1);
        run_check(1, 4'b1100, 1'b1);

        // Random gate tables on both instances.
        for (int i = 0; i < 10; i++) begin
            run_check(i % 2, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset while vector 2 is applied: immediate clear, no done pulse.
        gt[0] = 4'b0110;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        to = 0;
        while (!(a[0] === 1'b1 && b[0] === 1'b0) && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("reach_v2", {a[0], b[0]}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_all(0, "async_rst");
        chk("async_rst_err", err[0], 0);
        chk("async_rst_fv",  fv[0], 0);
        chk("async_rst_pass", pass[0], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", done[0], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_all(0, "post_rst");
        run_check(0, 4'b0110, 1'b0);

        // Held start: back-to-back runs with one DONE and one IDLE cycle between.
        gt[1] = 4'b1000;
        @(negedge clk); start[1] = 1'b1;
        wait_done(1);
        chk("b2b_pass1", pass[1], 1);
        chk("b2b_fv1",   fv[1], 0);
        gt[1] = 4'b0000;
        @(negedge clk);
        chk("b2b_idle_busy", busy[1], 0);
        chk("b2b_idle_done", done[1], 0);
        @(negedge clk);
        chk("b2b_restart", busy[1], 1);
        wait_done(1);
        chk("b2b_pass2", pass[1], 0);
        chk("b2b_err2",  err[1], 1);
        chk("b2b_fv2",   fv[1], 4'b1000);
        start[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_stop", busy[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
